// File: rtl/coverage_pkg.sv
// Shared bin numbering, counter widths and helpers for the coverage collector.
package coverage_pkg;

    localparam int NUM_BINS = 35;
    localparam int COUNT_W  = 32;
    localparam int TOTAL_W  = 64;

    typedef logic [5:0] bin_t;

    localparam bin_t BIN_C0 = 6'd32;
    localparam bin_t BIN_C1 = 6'd33;
    localparam bin_t BIN_C2 = 6'd34;

    function automatic logic [5:0] popcount(input logic [NUM_BINS-1:0] v);
        logic [5:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            sum = sum + {5'b0, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/coverage_classify.sv
// Maps a retired instruction to its opcode bin; trapped instructions land in no bin.
module coverage_classify
    import coverage_pkg::*;
(
    input  logic [6:0] insn,
    input  logic       trap,
    output logic       bin_valid,
    output bin_t       bin_idx
);

    // Full-width encodings use the major opcode; compressed ones use the quadrant.
    always_comb begin
        bin_valid = !trap;
        bin_idx   = '0;
        unique case (insn[1:0])
            2'b11:   bin_idx = {1'b0, insn[6:2]};
            2'b00:   bin_idx = BIN_C0;
            2'b01:   bin_idx = BIN_C1;
            default: bin_idx = BIN_C2;
        endcase
    end

endmodule

// File: rtl/coverage.sv
// Passive retirement-trace coverage collector: per-bin saturating counters and a sticky hit map.
// Optional macro FCOV_VERBOSE_EN prints each accepted sample in simulation.
module coverage
    import coverage_pkg::*;
#(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int FLEN   = 64,
    parameter int VLEN   = 256,
    parameter int NHART  = 1,
    parameter int RETIRE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NHART*RETIRE-1:0] valid,
    input  logic [ILEN-1:0]         insn,
    input  logic [XLEN-1:0]         pc,
    input  logic                    trap,
    input  logic                    clear,
    input  logic [5:0]              rd_addr,
    output logic [COUNT_W-1:0]      rd_count,
    output logic [NUM_BINS-1:0]     bins_hit,
    output logic [5:0]              bins_hit_num,
    output logic [TOTAL_W-1:0]      total_count,
    output logic [COUNT_W-1:0]      trap_count,
    output logic [XLEN-1:0]         last_pc
);

    localparam int unused_widths = FLEN + VLEN;

    logic [COUNT_W-1:0]  bin_count [NUM_BINS];
    logic [NUM_BINS-1:0] hit_next;
    logic                bin_valid;
    bin_t                bin_idx;
    logic                unused_bits;

    // Only hart 0 / slot 0 and the low opcode bits matter.
    assign unused_bits = ^{insn, valid};

    coverage_classify u_classify (
        .insn      (insn[6:0]),
        .trap      (trap),
        .bin_valid (bin_valid),
        .bin_idx   (bin_idx)
    );

    always_comb begin
        hit_next = bins_hit;
        if (valid[0] && bin_valid) begin
            hit_next[bin_idx] = 1'b1;
        end
    end

    // Clear beats a coincident sample; every counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_count[i] <= '0;
            end
            bins_hit     <= '0;
            bins_hit_num <= '0;
            total_count  <= '0;
            trap_count   <= '0;
            last_pc      <= '0;
        end else if (valid[0]) begin
            if (total_count != '1) begin
                total_count <= total_count + 1'b1;
            end
            last_pc <= pc;
            if (trap) begin
                if (trap_count != '1) begin
                    trap_count <= trap_count + 1'b1;
                end
            end else if (bin_valid) begin
                if (bin_count[bin_idx] != '1) begin
                    bin_count[bin_idx] <= bin_count[bin_idx] + 1'b1;
                end
            end
            bins_hit     <= hit_next;
            bins_hit_num <= popcount(hit_next);
        end
    end

    always_comb begin
        rd_count = '0;
        if (rd_addr < 6'(NUM_BINS)) begin
            rd_count = bin_count[rd_addr];
        end
    end

`ifdef FCOV_VERBOSE_EN
    always @(posedge clk) begin
        if (!reset && !clear && valid[0]) begin
            if (trap) begin
                $display("coverage: sample PC 0x%h insn 0x%h bin trap", pc, insn);
            end else begin
                $display("coverage: sample PC 0x%h insn 0x%h bin %0d", pc, insn, bin_idx);
            end
        end
    end
`endif

endmodule

// File: tb/tb_coverage.sv
// Bench for the coverage collector: directed scenarios then random traffic against a spec-level model.
module tb_coverage;
    import coverage_pkg::*;

    localparam int NH = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                clear;
    logic [NH-1:0]       valid;
    logic [31:0]         insn;
    logic [63:0]         pc;
    logic                trap;
    logic [5:0]          rd_addr;
    logic [COUNT_W-1:0]  rd_count;
    logic [NUM_BINS-1:0] bins_hit;
    logic [5:0]          bins_hit_num;
    logic [TOTAL_W-1:0]  total_count;
    logic [COUNT_W-1:0]  trap_count;
    logic [63:0]         last_pc;

    int checks = 0;
    int errors = 0;

    longint unsigned m_cnt [NUM_BINS];
    logic [NUM_BINS-1:0] m_hit;
    longint unsigned m_total;
    longint unsigned m_trap;
    logic [63:0]     m_pc;

    coverage #(
        .ILEN(32), .XLEN(64), .FLEN(64), .VLEN(256), .NHART(NH), .RETIRE(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .insn         (insn),
        .pc           (pc),
        .trap         (trap),
        .clear        (clear),
        .rd_addr      (rd_addr),
        .rd_count     (rd_count),
        .bins_hit     (bins_hit),
        .bins_hit_num (bins_hit_num),
        .total_count  (total_count),
        .trap_count   (trap_count),
        .last_pc      (last_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelStep(input logic v0, input logic wipe, input logic [31:0] ins,
                                      input logic tr, input logic [63:0] p);
        int b;
        if (wipe) begin
            for (int i = 0; i < NUM_BINS; i++) m_cnt[i] = 0;
            m_hit = '0; m_total = 0; m_trap = 0; m_pc = '0;
        end else if (v0) begin
            if (m_total != 64'hFFFF_FFFF_FFFF_FFFF) m_total++;
            m_pc = p;
            if (tr) begin
                if (m_trap < 64'hFFFF_FFFF) m_trap++;
            end else begin
                b = (ins[1:0] == 2'b11) ? int'(ins[6:2]) : 32 + int'(ins[1:0]);
                if (m_cnt[b] < 64'hFFFF_FFFF) m_cnt[b]++;
                m_hit[b] = 1'b1;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [NH-1:0] v, input logic clr, input logic rst,
                                 input logic tr, input logic [31:0] ins, input logic [63:0] p);
        @(negedge clk);
        valid = v; clear = clr; reset = rst; trap = tr; insn = ins; pc = p;
        @(posedge clk);
        modelStep(v[0], clr | rst, ins, tr, p);
        #1;
        valid = '0; clear = 1'b0; reset = 1'b0; trap = 1'b0;
    endtask

    task automatic readBin(input logic [5:0] a, output logic [COUNT_W-1:0] r);
        rd_addr = a;
        #1;
        r = rd_count;
    endtask

    task automatic checkModel(input string tag);
        logic [COUNT_W-1:0] r;
        checkOutput({tag, "_total"}, total_count, m_total);
        checkOutput({tag, "_trap"}, {32'b0, trap_count}, m_trap);
        checkOutput({tag, "_hit"}, {29'b0, bins_hit}, {29'b0, m_hit});
        checkOutput({tag, "_hitnum"}, {58'b0, bins_hit_num}, 64'($countones(m_hit)));
        checkOutput({tag, "_lastpc"}, last_pc, m_pc);
        for (int a = 0; a < 64; a++) begin
            readBin(6'(a), r);
            checkOutput($sformatf("%s_rd%0d", tag, a), {32'b0, r}, (a < NUM_BINS) ? m_cnt[a] : 64'd0);
        end
    endtask

    initial begin
        logic [COUNT_W-1:0] r;
        reset = 1'b1; clear = 1'b0; valid = '0; trap = 1'b0; insn = '0; pc = '0; rd_addr = '0;
        for (int i = 0; i < NUM_BINS; i++) m_cnt[i] = 0;
        m_hit = '0; m_total = 0; m_trap = 0; m_pc = '0;

        // Reset then idle
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        checkOutput("rst_total", total_count, 64'd0);
        checkOutput("rst_trap", {32'b0, trap_count}, 64'd0);
        checkOutput("rst_hit", {29'b0, bins_hit}, 64'd0);
        checkOutput("rst_hitnum", {58'b0, bins_hit_num}, 64'd0);
        readBin(6'h13, r);
        checkOutput("rst_rd13", {32'b0, r}, 64'd0);

        // Three addi retirements
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h8000_1000);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h8000_1004);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h8000_1008);
        readBin(6'd4, r);
        checkOutput("addi_cnt", {32'b0, r}, 64'd3);
        checkOutput("addi_hit", {29'b0, bins_hit}, 64'h10);
        checkOutput("addi_hitnum", {58'b0, bins_hit_num}, 64'd1);
        checkOutput("addi_total", total_count, 64'd3);
        checkOutput("addi_lastpc", last_pc, 64'h8000_1008);
        checkModel("addi");

        // Compressed quadrants
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_4505, 64'h200);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 64'h202);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_8082, 64'h204);
        readBin(6'd33, r); checkOutput("c1_cnt", {32'b0, r}, 64'd1);
        readBin(6'd32, r); checkOutput("c0_cnt", {32'b0, r}, 64'd1);
        readBin(6'd34, r); checkOutput("c2_cnt", {32'b0, r}, 64'd1);
        checkOutput("comp_hitnum", {58'b0, bins_hit_num}, 64'd3);

        // Trapped ecall
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 32'h0000_0073, 64'h300);
        checkOutput("trap_cnt", {32'b0, trap_count}, 64'd1);
        checkOutput("trap_total", total_count, 64'd1);
        readBin(6'd28, r); checkOutput("trap_bin28", {32'b0, r}, 64'd0);
        checkOutput("trap_hit", {29'b0, bins_hit}, 64'd0);

        // Clear with coincident sample, then a slot-1-only retirement
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h400);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0050_0093, 64'h404);
        checkModel("clrwin");
        checkOutput("clrwin_total", total_count, 64'd0);
        applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h408);
        checkOutput("slot1_total", total_count, 64'd0);
        checkOutput("slot1_hit", {29'b0, bins_hit}, 64'd0);

        // Saturation of a bin counter
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h500);
        @(negedge clk);
        dut.bin_count[4] = 32'hFFFF_FFFF;
        m_cnt[4] = 64'hFFFF_FFFF;
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0050_0093, 64'h504);
        readBin(6'd4, r); checkOutput("sat_cnt", {32'b0, r}, 64'hFFFF_FFFF);
        checkOutput("sat_total", total_count, 64'd2);
        readBin(6'd40, r); checkOutput("rd40", {32'b0, r}, 64'd0);
        checkModel("sat");

        // Random traffic
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        for (int n = 0; n < 400; n++) begin
            applyStimulus(NH'($urandom), ($urandom_range(0, 29) == 0), 1'b0,
                          ($urandom_range(0, 7) == 0), $urandom, {$urandom, $urandom});
            if (n % 50 == 49) checkModel($sformatf("rnd%0d", n));
        end
        checkModel("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coverage.md
Name: coverage

Overview:
- Functional-coverage collector for the RISC-V architectural verification harness.
- Snoops the retirement trace (valid, instruction, PC, trap) and classifies each retired instruction into opcode bins.
- Keeps hit bitmaps and saturating counters that the harness can read back.
- Sits beside the core as a passive observer; it never drives the core.

Parameters:
- ILEN, 32: instruction width in bits. Only bits [15:0]/[31:0] are decoded.
- XLEN, 64: PC width in bits.
- FLEN, 64: FP register width. Carried for interface compatibility; unused.
- VLEN, 256: vector length. Carried for interface compatibility; unused.
- NHART, 1: number of harts on the trace.
- RETIRE, 1: retire slots per hart.

Ports:
- clk  in  1  Trace clock. All state updates on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- valid  in  NHART*RETIRE  Per-slot retire valid. Only bit 0 (hart 0, slot 0) is sampled.
- insn  in  ILEN  Retired instruction for slot 0.
- pc  in  XLEN  PC of the retired instruction for slot 0.
- trap  in  1  Slot-0 instruction trapped.
- clear  in  1  Synchronous clear of all coverage state.
- rd_addr  in  6  Bin index for the read port.
- rd_count  out  32  Counter of bin rd_addr. Combinational read.
- bins_hit  out  35  Sticky hit bitmap, one bit per bin.
- bins_hit_num  out  6  Population count of bins_hit.
- total_count  out  64  Retired-valid samples.
- trap_count  out  32  Trapped samples.
- last_pc  out  XLEN  PC of the most recent sample.

Behaviour:
- Reset (synchronous, active-high):
  - All counters, bins_hit, bins_hit_num and last_pc are 0.
  - rd_count reads 0.
- clear has identical effect to reset. Reset or clear asserted together with valid[0]: the clear wins and that sample is dropped.
- Sample condition: valid[0]==1 at a rising clk while not in reset/clear. All other valid bits are ignored.
- Latency: every output reflects a sample one cycle after the sampling edge.
- For each sample:
  - total_count increments; last_pc <= pc.
  - If trap==1: trap_count increments; no opcode bin is updated.
  - If trap==0, classify the instruction:
    - insn[1:0]==2'b11: 32-bit instruction, bin = insn[6:2] (0..31).
    - insn[1:0]==2'b00: compressed quadrant 0, bin 32.
    - insn[1:0]==2'b01: compressed quadrant 1, bin 33.
    - insn[1:0]==2'b10: compressed quadrant 2, bin 34.
  - The selected bin counter increments and bins_hit[bin] is set (sticky).
- All counters saturate at their all-ones value; they never wrap.
- bins_hit_num is registered and equals popcount(bins_hit) after the update.
- rd_count = counter[rd_addr] for rd_addr 0..34; rd_addr 35..63 reads 0.
- Multi-hart and multi-retire traces: slots other than [0][0] are not covered. There is no ordering logic.

Optional Feature:
- Macro: FCOV_VERBOSE_EN.
- Defined: each accepted sample issues a simulation $display of "coverage: sample PC 0x<pc> insn 0x<insn> bin <n|trap>". Simulation-only; no hardware change.
- Undefined: no display. Logic is identical in both cases.

Decomposition:
- Package coverage_pkg holds:
  - NUM_BINS=35 and bin index constants BIN_C0=32, BIN_C1=33, BIN_C2=34.
  - bin_t (6-bit index typedef).
  - COUNT_W=32 and TOTAL_W=64.
- One sub-module, coverage_classify: purely combinational mapping insn, trap to (bin_valid, bin_idx).
- Counters, bitmap and popcount live in the top.

Test Plan:
- Reset then idle:
  - total_count=0, trap_count=0, bins_hit=0, bins_hit_num=0, rd_count at addr 0x13 = 0.
- Sample insn 0x00500093 (addi, opcode 0x13) three times, then read:
  - bin 4 count = 3, bins_hit = 1<<4, bins_hit_num = 1, total_count = 3, last_pc = last driven PC.
- Sample compressed 0x4505, then 0x0000_0000, then 0x8082, each trap=0:
  - bins 33, 32, 34 each count 1; bins_hit_num = 3.
- Sample insn 0x00000073 with trap=1:
  - trap_count = 1, total_count = 1, bin 28 count = 0, bins_hit = 0.
- Assert valid[0] together with clear:
  - Everything reads 0 next cycle. With valid=2'b10 (NHART=2), no counter changes.
- Force bin 4 counter to 0xFFFFFFFF, then sample addi:
  - Count stays 0xFFFFFFFF; total_count still increments. Read rd_addr=40 returns 0.
